fwd_select_unit: RTL and testbench
==================================

Name: fwd_select_unit

Overview:
- Generates the 2-bit select codes that drive the EX-stage 4:1 ALU operand muxes, one code per operand (A and B).
- Tracks destination-register and write-enable metadata as each instruction moves ID→EX→MEM→WB.
- Compares ID-stage source registers against in-flight producers and registers the result, so the select is valid while the consumer is in EX.
- Sits beside the ID/EX pipeline register in the 5-stage RISC-V core.

Parameters:
- REG_ADDR_W, 5, architectural register index width.
- SEL_W, 2, operand-mux select width (matches 4:1 mux control).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_ADDR_W  ID source register 1.
- id_rs2  input  REG_ADDR_W  ID source register 2.
- id_rd  input  REG_ADDR_W  ID destination register.
- id_reg_write  input  1  ID instruction writes rd.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  squash the instruction entering EX (branch/jump redirect).
- fwd_a_sel  output  SEL_W  operand A mux select, valid in EX.
- fwd_b_sel  output  SEL_W  operand B mux select, valid in EX.
- stall  output  1  hold PC and IF/ID; insert bubble into EX.

Behaviour:
- Reset (async, rst=1): all tracking registers (ex_rd, ex_we, ex_ld, mem_rd, mem_we) = 0; fwd_a_sel = fwd_b_sel = 00; stall = 0. The unit is usable on the first edge after rst deasserts.
- Select encoding, as decoded by the operand mux:
  - 00 → in4, register-file value.
  - 01 → in3, WB result.
  - 10 → in2, MEM ALU result.
  - 11 → in1, reserved; never driven.
- Each edge, the next select for operand X (rs = id_rs1 or id_rs2) is:
  - 10 if ex_we && ex_rd == rs && rs != 0. The producer now in EX reaches MEM next cycle.
  - else 01 if mem_we && mem_rd == rs && rs != 0. The producer reaches WB next cycle.
  - else 00.
  - The MEM path has priority over WB, so the most recent producer wins.
- Next select is forced to 00 when !id_valid, stall, or flush.
- Outputs are registered. Latency is one cycle: the ID-time compare appears on fwd_*_sel while the consumer is in EX.
- Stage advance each edge:
  - mem_* ← ex_*.
  - ex_* ← {id_rd, id_reg_write && id_valid, id_mem_read && id_valid}.
  - If flush or stall, ex_* ← 0 (bubble).
- Priority rules:
  - flush and stall both high → flush wins; the result is a bubble either way.
  - flush does not clear mem_* (the older instruction commits).
- x0 is never forwarded, regardless of write-enable.
- A WB-stage producer versus an ID-stage consumer is not handled here. The register file is write-first.
- id_rd == 0 with id_reg_write = 1 is tracked, but it never matches because of the rs != 0 rule.

Optional Feature:
- Macro: FWD_LOAD_STALL_EN.
- When defined:
  - stall = id_valid && ex_ld && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2). This is combinational in the same cycle.
  - The following cycle EX receives a bubble. The load then sits in MEM, and the retried consumer gets select 01 when it enters EX.
- When undefined:
  - stall is tied to 0 and ex_ld is not implemented.
  - Loads forward through the normal MEM-priority path. Software must place one independent instruction after each load.

Decomposition:
- Shared parameters header:
  - FWD_SEL_REGFILE = 2'b00, FWD_SEL_WB = 2'b01, FWD_SEL_MEM = 2'b10, FWD_SEL_RSVD = 2'b11.
  - REG_ADDR_WIDTH = 5.
- One natural sub-module, fwd_operand_cmp. It is combinational: rs + EX/MEM metadata → 2-bit next select. It is instantiated twice (operands A and B).
- Stage registers and stall logic stay in the top.

Test Plan:
- Reset mid-stream: assert rst while ex_we = 1 → fwd_a_sel = fwd_b_sel = 00 and stall = 0 immediately; first post-reset instruction with rs1 = 5 gets sel 00.
- Back-to-back dependency: add x5 (cycle 0), then add rs1 = x5 (cycle 1) → fwd_a_sel = 10 in cycle 2. One-instruction gap → 01. Two-instruction gap → 00.
- Double producer: writes to x7 in consecutive cycles, then consumer rs2 = x7 → fwd_b_sel = 10 (MEM priority over WB).
- x0 and invalid cases:
  - Producer rd = 0 with reg_write = 1, consumer rs1 = 0 → sel 00.
  - id_valid = 0 with matching rs → sel 00.
- Flush: flush = 1 with matching rs1 → next fwd_a_sel = 00; ex_we = 0 next cycle; an older MEM producer still forwards 01 to the following consumer.
- Load-use (FWD_LOAD_STALL_EN): lw x9 then add rs1 = x9 → stall = 1 for exactly one cycle, EX bubble, then fwd_a_sel = 01. Without the macro, stall stays 0 and fwd_a_sel = 10.

Source files
------------

// File: rtl/fwd_select_unit_pkg.sv
// Shared constants for the EX-stage operand forwarding select logic.
// Select codes match the 4:1 operand mux control (in4..in1).
package fwd_select_unit_pkg;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [1:0] FWD_SEL_REGFILE = 2'b00;
    localparam logic [1:0] FWD_SEL_WB      = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM     = 2'b10;
    localparam logic [1:0] FWD_SEL_RSVD    = 2'b11;
endpackage

// File: rtl/fwd_operand_cmp.sv
// Combinational next-select for one ALU operand: compares the ID source
// register against the EX and MEM producers, newest producer first.
module fwd_operand_cmp
    import fwd_select_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_WIDTH,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_we,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_we,
    output logic [SEL_W-1:0]      sel
);
    always_comb begin
        sel = SEL_W'(FWD_SEL_REGFILE);
        // x0 is hardwired zero, so a write to it never forwards
        if (rs != '0) begin
            if (ex_we && ex_rd == rs)
                sel = SEL_W'(FWD_SEL_MEM);
            else if (mem_we && mem_rd == rs)
                sel = SEL_W'(FWD_SEL_WB);
        end
    end
endmodule

// File: rtl/fwd_select_unit.sv
// Forwarding select generator beside the ID/EX register: tracks rd/we through
// EX and MEM and registers per-operand mux selects. FWD_LOAD_STALL_EN adds load-use stall.
module fwd_select_unit
    import fwd_select_unit_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_WIDTH,
    parameter int SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic                  stall
);
    localparam int NUM_OPS = 2;

    logic [REG_ADDR_W-1:0]               ex_rd, mem_rd;
    logic                                ex_we, mem_we;
    logic [NUM_OPS-1:0][REG_ADDR_W-1:0]  rs;
    logic [NUM_OPS-1:0][SEL_W-1:0]       nxt_sel, sel_q;
    logic                                bubble;

    assign rs        = {id_rs2, id_rs1};
    assign bubble    = flush || stall;
    assign fwd_a_sel = sel_q[0];
    assign fwd_b_sel = sel_q[1];

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fwd_operand_cmp #(
            .REG_ADDR_W (REG_ADDR_W),
            .SEL_W      (SEL_W)
        ) u_cmp (
            .rs     (rs[i]),
            .ex_rd  (ex_rd),
            .ex_we  (ex_we),
            .mem_rd (mem_rd),
            .mem_we (mem_we),
            .sel    (nxt_sel[i])
        );
    end

    // MEM always advances, even on flush: the older instruction still commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rd  <= '0;
            ex_we  <= 1'b0;
            mem_rd <= '0;
            mem_we <= 1'b0;
            sel_q  <= '0;
        end else begin
            mem_rd <= ex_rd;
            mem_we <= ex_we;
            if (bubble) begin
                ex_rd <= '0;
                ex_we <= 1'b0;
                sel_q <= '0;
            end else begin
                ex_rd <= id_rd;
                ex_we <= id_reg_write && id_valid;
                sel_q <= id_valid ? nxt_sel : '0;
            end
        end
    end

`ifdef FWD_LOAD_STALL_EN
    logic ex_ld;

    // Load data is not ready until WB, so a dependent op waits one cycle
    assign stall = id_valid && ex_ld && (ex_rd != '0) &&
                   (ex_rd == id_rs1 || ex_rd == id_rs2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ex_ld <= 1'b0;
        else
            ex_ld <= !bubble && id_mem_read && id_valid;
    end
`else
    logic unused_mem_read;

    assign unused_mem_read = id_mem_read;
    assign stall           = 1'b0;
`endif
endmodule

// File: tb/tb_fwd_select_unit.sv
// Directed bench for fwd_select_unit; expectations are hand-computed and
// follow FWD_LOAD_STALL_EN when it is defined.
module tb_fwd_select_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    fwd_select_unit #(.REG_ADDR_W(5), .SEL_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall)
    );

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic ld, input logic fl);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = we;
        id_mem_read  = ld;
        flush        = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        @(posedge clk); #1;
        check("rst_a", fwd_a_sel, 2'b00);
        check("rst_b", fwd_b_sel, 2'b00);
        check("rst_stall", {1'b0, stall}, 2'b00);
        rst = 1'b0;

        // back-to-back dependency: add x5; add rs1=x5 -> 10
        drive(1, 0, 0, 5, 1, 0, 0); tick;
        check("b2b_prod_a", fwd_a_sel, 2'b00);
        drive(1, 5, 0, 6, 1, 0, 0); tick;
        check("b2b_a", fwd_a_sel, 2'b10);
        check("b2b_b", fwd_b_sel, 2'b00);

        // reset mid-stream while ex_we=1 clears outputs immediately
        #2 rst = 1'b1;
        #1;
        check("midrst_a", fwd_a_sel, 2'b00);
        check("midrst_b", fwd_b_sel, 2'b00);
        check("midrst_stall", {1'b0, stall}, 2'b00);
        tick;
        rst = 1'b0;
        drive(1, 5, 6, 0, 0, 0, 0); tick;
        check("postrst_a", fwd_a_sel, 2'b00);
        check("postrst_b", fwd_b_sel, 2'b00);

        // one-instruction gap -> 01
        drive(1, 0, 0, 5, 1, 0, 0); tick;
        drive(1, 1, 2, 3, 0, 0, 0); tick;
        drive(1, 5, 0, 0, 0, 0, 0); tick;
        check("gap1_a", fwd_a_sel, 2'b01);

        // two-instruction gap -> 00
        drive(1, 0, 0, 5, 1, 0, 0); tick;
        drive(1, 1, 2, 3, 0, 0, 0); tick;
        drive(1, 1, 2, 3, 0, 0, 0); tick;
        drive(1, 5, 0, 0, 0, 0, 0); tick;
        check("gap2_a", fwd_a_sel, 2'b00);

        // one-gap on operand B -> 01
        drive(1, 0, 0, 8, 1, 0, 0); tick;
        drive(1, 1, 2, 3, 0, 0, 0); tick;
        drive(1, 0, 8, 0, 0, 0, 0); tick;
        check("gap1_b", fwd_b_sel, 2'b01);
        check("gap1_b_a", fwd_a_sel, 2'b00);

        // double producer of x7: MEM beats WB
        drive(1, 0, 0, 7, 1, 0, 0); tick;
        drive(1, 0, 0, 7, 1, 0, 0); tick;
        drive(1, 7, 7, 0, 0, 0, 0); tick;
        check("dbl_b", fwd_b_sel, 2'b10);
        check("dbl_a", fwd_a_sel, 2'b10);

        // x0 producer never forwards
        drive(1, 0, 0, 0, 1, 0, 0); tick;
        drive(1, 0, 0, 0, 0, 0, 0); tick;
        check("x0_a", fwd_a_sel, 2'b00);
        check("x0_b", fwd_b_sel, 2'b00);

        // invalid consumer gets 00; invalid producer is not tracked
        drive(1, 0, 0, 10, 1, 0, 0); tick;
        drive(0, 10, 10, 11, 1, 0, 0); tick;
        check("inv_cons_a", fwd_a_sel, 2'b00);
        check("inv_cons_b", fwd_b_sel, 2'b00);
        drive(1, 11, 10, 0, 0, 0, 0); tick;
        check("inv_prod_a", fwd_a_sel, 2'b00);
        check("inv_prod_b", fwd_b_sel, 2'b01);

        // flush: forced 00, bubble in EX, older MEM producer still forwards
        drive(1, 0, 0, 12, 1, 0, 0); tick;
        drive(1, 12, 0, 13, 1, 0, 1); tick;
        check("flush_a", fwd_a_sel, 2'b00);
        drive(1, 12, 13, 0, 0, 0, 0); tick;
        check("flush_mem_a", fwd_a_sel, 2'b01);
        check("flush_bub_b", fwd_b_sel, 2'b00);

        // load-use: lw x9; add rs1=x9
        drive(1, 0, 0, 9, 1, 1, 0); tick;
        drive(1, 9, 0, 14, 1, 0, 0);
`ifdef FWD_LOAD_STALL_EN
        check("lu_stall", {1'b0, stall}, 2'b01);
        tick;
        check("lu_bubble_a", fwd_a_sel, 2'b00);
        check("lu_stall_clr", {1'b0, stall}, 2'b00);
        tick;
        check("lu_retry_a", fwd_a_sel, 2'b01);
`else
        check("lu_stall", {1'b0, stall}, 2'b00);
        tick;
        check("lu_fwd_a", fwd_a_sel, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("lu_stall_clr", {1'b0, stall}, 2'b00);
        tick;
        check("lu_idle_a", fwd_a_sel, 2'b00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
